// File: rtl/qpsk_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_frame_rx
// Description : QPSK time-link deframer. It hunts for the header in the serial
//               bitstream, collects the 32-bit h/m/s/cs payload and verifies it.
//               Optional build macro: QPSK_RX_BCD_CHECK_EN adds BCD range checks.
// Revision    : 1.0 - initial release
// ============================================================================
module qpsk_frame_rx #(
    parameter logic [7:0]  HEADER   = 8'hcc,
    parameter int unsigned MISS_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_i,
    input  logic        bit_vld,
    output logic [7:0]  h_o,
    output logic [7:0]  m_o,
    output logic [7:0]  s_o,
    output logic [39:0] frame_o,
    output logic        frame_vld,
    output logic        lock,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam logic [3:0] c_miss_max = 4'(MISS_MAX);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_hunt;
    logic [31:0] r_pay;
    logic [5:0]  r_cnt;
    logic [3:0]  r_miss;
    logic [39:0] r_frame;
    logic        r_frame_vld;
    logic        r_lock;
    logic [15:0] r_err;

    logic [7:0]  w_hunt_shift;
    logic [7:0]  w_sum;
    logic        w_fields_ok;
    logic        w_pass;
    logic [3:0]  w_miss_inc;

    assign w_hunt_shift = {r_hunt[6:0], bit_i};
    assign w_sum        = r_pay[31:24] + r_pay[23:16] + r_pay[15:8];

`ifdef QPSK_RX_BCD_CHECK_EN
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    assign w_fields_ok = bcd_ok(r_pay[31:24], 8'h23) &&
                         bcd_ok(r_pay[23:16], 8'h59) &&
                         bcd_ok(r_pay[15:8],  8'h59);
`else
    assign w_fields_ok = 1'b1;
`endif

    assign w_pass     = (w_sum == r_pay[7:0]) && w_fields_ok;
    assign w_miss_inc = (r_miss >= c_miss_max) ? r_miss : r_miss + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT:    if (bit_vld && (w_hunt_shift == HEADER)) w_state_next = ST_PAYLOAD;
            ST_PAYLOAD: if (bit_vld && (r_cnt == 6'd31))         w_state_next = ST_CHECK;
            ST_CHECK:   w_state_next = ST_HUNT;
            default:    w_state_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hunt      <= '0;
            r_pay       <= '0;
            r_cnt       <= '0;
            r_miss      <= '0;
            r_frame     <= '0;
            r_frame_vld <= 1'b0;
            r_lock      <= 1'b0;
            r_err       <= '0;
        end else begin
            r_frame_vld <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (bit_vld) begin
                        r_hunt <= w_hunt_shift;
                        if (w_hunt_shift == HEADER) r_cnt <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (bit_vld) begin
                        r_pay <= {r_pay[30:0], bit_i};
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_CHECK: begin
                    // Any bit arriving here is intentionally dropped.
                    r_hunt <= '0;
                    if (w_pass) begin
                        r_frame     <= {HEADER, r_pay};
                        r_frame_vld <= 1'b1;
                        r_lock      <= 1'b1;
                        r_miss      <= '0;
                    end else begin
                        r_err  <= (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
                        r_miss <= w_miss_inc;
                        if (w_miss_inc >= c_miss_max) r_lock <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame_o   = r_frame;
    assign h_o       = r_frame[31:24];
    assign m_o       = r_frame[23:16];
    assign s_o       = r_frame[15:8];
    assign frame_vld = r_frame_vld;
    assign lock      = r_lock;
    assign err_cnt   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_qpsk_frame_rx
// Description : Table-driven self-checking bench for qpsk_frame_rx with a
//               frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qpsk_frame_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_i;
    logic        bit_vld;
    logic [7:0]  h_o;
    logic [7:0]  m_o;
    logic [7:0]  s_o;
    logic [39:0] frame_o;
    logic        frame_vld;
    logic        lock;
    logic [15:0] err_cnt;

    always #10 clk = ~clk;

    qpsk_frame_rx dut (
        .clk       (clk),
        .rst       (rst),
        .bit_i     (bit_i),
        .bit_vld   (bit_vld),
        .h_o       (h_o),
        .m_o       (m_o),
        .s_o       (s_o),
        .frame_o   (frame_o),
        .frame_vld (frame_vld),
        .lock      (lock),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic [39:0] frame;
        int          ng;
        logic [15:0] garb;
        logic        pass;
        logic [15:0] err;
        logic        lock;
    } vec_t;

    localparam int NV = 9;
    vec_t        tv[NV];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [39:0] last_good;
    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];

    // Capture every accepted frame the DUT announces.
    always @(negedge clk) begin
        if (frame_vld) got_q.push_back(frame_o);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        bit_i   = b;
        bit_vld = 1'b1;
        @(posedge clk); #1;
        bit_vld = 1'b0;
    endtask

    task automatic send_bits(input logic [39:0] f, input int n);
        for (int k = 39; k >= 40 - n; k--) begin
            send_bit(f[k]);
            if (k != 40 - n) repeat (2) @(posedge clk);
        end
    endtask

    task automatic chk_held();
        chk("frame_o", frame_o, last_good);
        chk("h_o", h_o, last_good[31:24]);
        chk("m_o", m_o, last_good[23:16]);
        chk("s_o", s_o, last_good[15:8]);
    endtask

    task automatic run_frame(input logic [39:0] f, input logic pass, input logic [15:0] err,
                             input logic lk, input logic inject);
        if (pass) exp_q.push_back(f);
        send_bits(f, 40);
        chk("vld_in_check", frame_vld, 1'b0);
        if (inject) begin
            bit_i   = 1'b1;
            bit_vld = 1'b1;
        end
        @(posedge clk); #1;
        bit_vld = 1'b0;
        chk("frame_vld", frame_vld, pass);
        chk("err_cnt", err_cnt, err);
        chk("lock", lock, lk);
        if (pass) last_good = f;
        chk_held();
        @(posedge clk); #1;
        chk("vld_width", frame_vld, 1'b0);
        repeat (3) @(posedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_frame_o"}, frame_o, 40'h0);
        chk({tag, "_hms"}, {h_o, m_o, s_o}, 24'h0);
        chk({tag, "_frame_vld"}, frame_vld, 1'b0);
        chk({tag, "_lock"}, lock, 1'b0);
        chk({tag, "_err_cnt"}, err_cnt, 16'h0);
    endtask

    initial begin
        tv[0] = '{40'hcc_12_34_56_9c, 0,  16'h0,    1'b1, 16'd0, 1'b1};
        tv[1] = '{40'hcc_12_34_56_9c, 13, 16'h1555, 1'b1, 16'd0, 1'b1};
        tv[2] = '{40'hcc_12_34_56_9d, 0,  16'h0,    1'b0, 16'd1, 1'b1};
        tv[3] = '{40'hcc_12_34_56_9d, 0,  16'h0,    1'b0, 16'd2, 1'b1};
        tv[4] = '{40'hcc_12_34_56_9d, 0,  16'h0,    1'b0, 16'd3, 1'b0};
        tv[5] = '{40'hcc_23_59_59_d5, 0,  16'h0,    1'b1, 16'd3, 1'b1};
`ifdef QPSK_RX_BCD_CHECK_EN
        tv[6] = '{40'hcc_25_00_00_25, 0,  16'h0,    1'b0, 16'd4, 1'b1};
        tv[7] = '{40'hcc_80_90_a0_b0, 0,  16'h0,    1'b0, 16'd5, 1'b1};
        tv[8] = '{40'hcc_cc_cc_00_98, 0,  16'h0,    1'b0, 16'd6, 1'b0};
`else
        tv[6] = '{40'hcc_25_00_00_25, 0,  16'h0,    1'b1, 16'd3, 1'b1};
        tv[7] = '{40'hcc_80_90_a0_b0, 0,  16'h0,    1'b1, 16'd3, 1'b1};
        tv[8] = '{40'hcc_cc_cc_00_98, 0,  16'h0,    1'b1, 16'd3, 1'b1};
`endif

        rst       = 1'b1;
        bit_i     = 1'b0;
        bit_vld   = 1'b0;
        last_good = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("reset");

        for (int i = 0; i < NV; i++) begin
            for (int k = tv[i].ng - 1; k >= 0; k--) begin
                send_bit(tv[i].garb[k]);
                repeat (2) @(posedge clk);
            end
            run_frame(tv[i].frame, tv[i].pass, tv[i].err, tv[i].lock, 1'b0);
        end

        // Reset in the middle of a payload, coinciding with a valid bit.
        send_bits(40'hcc_12_34_56_9c, 28);
        repeat (2) @(posedge clk); #1;
        rst     = 1'b1;
        bit_i   = 1'b1;
        bit_vld = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        bit_vld = 1'b0;
        last_good = '0;
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        run_frame(40'hcc_12_34_56_9c, 1'b1, 16'd0, 1'b1, 1'b0);

        // A stray bit during the check cycle is ignored.
        run_frame(40'hcc_01_02_03_06, 1'b1, 16'd0, 1'b1, 1'b1);
        run_frame(40'hcc_10_20_30_60, 1'b1, 16'd0, 1'b1, 1'b0);

        repeat (4) @(posedge clk); #1;
        chk("sb_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("sb_frame", got_q[i], exp_q[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
